// File: rtl/bcd_7seg_scan_pkg.sv
// Shared definitions for the BCD 7-segment scanner: segment patterns (active-low {g,f,e,d,c,b,a}),
// update FSM state encodings and digit index codes.
package bcd_7seg_scan_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [2:0] AN_OFF   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIG_UND = 2'd0,
        DIG_DEC = 2'd1,
        DIG_CEN = 2'd2
    } digit_t;

    function automatic digit_t next_digit(input digit_t d);
        case (d)
            DIG_UND: return DIG_DEC;
            DIG_DEC: return DIG_CEN;
            default: return DIG_UND;
        endcase
    endfunction

    // Anode vector is {CEN,DEC,UND}, one-hot active-low.
    function automatic logic [2:0] anode_of(input digit_t d);
        case (d)
            DIG_UND: return 3'b110;
            DIG_DEC: return 3'b101;
            DIG_CEN: return 3'b011;
            default: return AN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash, blank forces all
// segments off.
module bcd_to_7seg
    import bcd_7seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Periodically requests a binary-to-BCD conversion, latches the three digits on completion and
// scans them onto a 3-digit multiplexed 7-segment display.
//   state  | meaning
//   S_IDLE | update counter running towards the next request
//   S_REQ  | out_INIT pulse to the converter (one cycle)
//   S_WAIT | waiting for in_DONE, then latch digits
module bcd_7seg_scan
    import bcd_7seg_scan_pkg::*;
#(
    parameter int UPDATE_DIV  = 1_000_000,
    parameter int REFRESH_DIV = 50_000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       out_INIT,
    input  logic       in_DONE,
    input  logic [3:0] in_UND,
    input  logic [3:0] in_DEC,
    input  logic [3:0] in_CEN,
    output logic [6:0] out_SEG,
    output logic [2:0] out_AN,
    output logic       out_VALID
);

    localparam int UPD_W = $clog2(UPDATE_DIV);
    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [UPD_W-1:0] upd_cnt;
    logic [REF_W-1:0] ref_cnt;
    digit_t           digit_idx;
    logic [3:0]       dig_und;
    logic [3:0]       dig_dec;
    logic [3:0]       dig_cen;
    logic             upd_tc;
    logic             ref_tc;
    logic             latch;
    logic [3:0]       cur_bcd;
    logic             cur_blank;
    logic [6:0]       cur_seg;

    assign upd_tc = (upd_cnt == UPD_W'(UPDATE_DIV - 1));
    assign ref_tc = (ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_INIT  = 1'b0;
        latch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (upd_tc) state_nxt = S_REQ;
            end
            S_REQ: begin
                out_INIT  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (in_DONE) begin
                    latch     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frozen outside S_IDLE so the next request comes UPDATE_DIV cycles after each latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt <= '0;
        end else if (state == S_IDLE) begin
            upd_cnt <= upd_tc ? '0 : upd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_und   <= '0;
            dig_dec   <= '0;
            dig_cen   <= '0;
            out_VALID <= 1'b0;
        end else if (latch) begin
            dig_und   <= in_UND;
            dig_dec   <= in_DEC;
            dig_cen   <= in_CEN;
            out_VALID <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt   <= '0;
            digit_idx <= DIG_UND;
        end else if (ref_tc) begin
            ref_cnt   <= '0;
            digit_idx <= next_digit(digit_idx);
        end else begin
            ref_cnt   <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_bcd   = dig_und;
        cur_blank = 1'b0;
        case (digit_idx)
            DIG_DEC: begin
                cur_bcd   = dig_dec;
                cur_blank = BLANK_LZ && (dig_cen == 4'd0) && (dig_dec == 4'd0);
            end
            DIG_CEN: begin
                cur_bcd   = dig_cen;
                cur_blank = BLANK_LZ && (dig_cen == 4'd0);
            end
            default: ;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd   (cur_bcd),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

    // Anode and segments are registered together from the same index so a slot never shows
    // its neighbour's pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_AN  <= AN_OFF;
            out_SEG <= SEG_OFF;
        end else if (!out_VALID) begin
            out_AN  <= AN_OFF;
            out_SEG <= SEG_OFF;
        end else begin
            out_AN  <= anode_of(digit_idx);
            out_SEG <= cur_seg;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan: a converter model answers each INIT, expected digit patterns are
// queued when the answer is driven and compared against every scanned display cycle.
module tb_bcd_7seg_scan;

    typedef struct packed {
        logic [6:0] und;
        logic [6:0] dec;
        logic [6:0] cen;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_done;
    logic [3:0] in_und;
    logic [3:0] in_dec;
    logic [3:0] in_cen;
    logic       init_b;
    logic       valid_b;
    logic [6:0] seg_b;
    logic [2:0] an_b;
    logic       init_n;
    logic       valid_n;
    logic [6:0] seg_n;
    logic [2:0] an_n;

    int   tests;
    int   fails;
    int   cyc;
    int   mark;
    exp_t q_b[$];
    exp_t q_n[$];
    exp_t cur_b;
    exp_t cur_n;

    bcd_7seg_scan #(.UPDATE_DIV(16), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .out_INIT(init_b), .in_DONE(in_done),
        .in_UND(in_und), .in_DEC(in_dec), .in_CEN(in_cen),
        .out_SEG(seg_b), .out_AN(an_b), .out_VALID(valid_b)
    );

    bcd_7seg_scan #(.UPDATE_DIV(16), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .out_INIT(init_n), .in_DONE(in_done),
        .in_UND(in_und), .in_DEC(in_dec), .in_CEN(in_cen),
        .out_SEG(seg_n), .out_AN(an_n), .out_VALID(valid_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c,
                                   input bit blz);
        exp_t e;
        e.und = pat(u);
        e.dec = (blz && c == 4'd0 && d == 4'd0) ? 7'b1111111 : pat(d);
        e.cen = (blz && c == 4'd0) ? 7'b1111111 : pat(c);
        return e;
    endfunction

    function automatic logic [2:0] next_an(input logic [2:0] a);
        case (a)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            3'b011:  return 3'b110;
            default: return 3'bxxx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        check("rst_init",    32'(init_b),  32'd0);
        check("rst_seg",     32'(seg_b),   32'(7'b1111111));
        check("rst_an",      32'(an_b),    32'(3'b111));
        check("rst_valid",   32'(valid_b), 32'd0);
        check("rst_init_nb", 32'(init_n),  32'd0);
        check("rst_seg_nb",  32'(seg_n),   32'(7'b1111111));
        check("rst_an_nb",   32'(an_n),    32'(3'b111));
        check("rst_valid_nb",32'(valid_n), 32'd0);
    endtask

    task automatic check_slot();
        case (an_b)
            3'b110:  check("seg_und", 32'(seg_b), 32'(cur_b.und));
            3'b101:  check("seg_dec", 32'(seg_b), 32'(cur_b.dec));
            3'b011:  check("seg_cen", 32'(seg_b), 32'(cur_b.cen));
            default: check("an_onehot", 32'(an_b), 32'(3'b110));
        endcase
        case (an_n)
            3'b110:  check("seg_und_nb", 32'(seg_n), 32'(cur_n.und));
            3'b101:  check("seg_dec_nb", 32'(seg_n), 32'(cur_n.dec));
            3'b011:  check("seg_cen_nb", 32'(seg_n), 32'(cur_n.cen));
            default: check("an_onehot_nb", 32'(an_n), 32'(3'b110));
        endcase
    endtask

    task automatic scan_check(input int n);
        logic [2:0] prev;
        int         run;
        bit         first;
        prev  = an_b;
        run   = 1;
        first = 1'b1;
        check_slot();
        for (int i = 1; i < n; i++) begin
            tick();
            if (an_b !== prev) begin
                check("an_order", 32'(an_b), 32'(next_an(prev)));
                if (!first) check("an_run", 32'(run), 32'd4);
                first = 1'b0;
                run   = 1;
                prev  = an_b;
            end else begin
                run++;
            end
            check("an_run_max", 32'(run <= 4), 32'd1);
            check_slot();
        end
    endtask

    task automatic wait_init();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (init_b) seen = 1'b1;
        end
        check("init_seen",  32'(seen), 32'd1);
        check("init_cycle", 32'(cyc - mark), 32'd16);
    endtask

    // Converter model: answers 10 cycles after INIT with the given digits.
    task automatic convert(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
        int pulses;
        pulses = 0;
        wait_init();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (init_b) pulses++;
        end
        check("init_single", 32'(pulses), 32'd0);
        in_done = 1'b1;
        in_und  = u;
        in_dec  = d;
        in_cen  = c;
        q_b.push_back(model(u, d, c, 1'b1));
        q_n.push_back(model(u, d, c, 1'b0));
        tick();
        in_done = 1'b0;
        in_und  = 4'hF;
        in_dec  = 4'hF;
        in_cen  = 4'hF;
        mark    = cyc;
        check("valid_rise",    32'(valid_b), 32'd1);
        check("valid_rise_nb", 32'(valid_n), 32'd1);
        cur_b = q_b.pop_front();
        cur_n = q_n.pop_front();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        mark    = 0;
        rst     = 1'b0;
        in_done = 1'b0;
        in_und  = 4'd0;
        in_dec  = 4'd0;
        in_cen  = 4'd0;
        repeat (3) tick();
        reset_checks();
        rst  = 1'b1;
        mark = cyc;

        convert(4'd3, 4'd2, 4'd1);
        in_done = 1'b1;
        in_und  = 4'd9;
        in_dec  = 4'd9;
        in_cen  = 4'd9;
        tick();
        in_done = 1'b0;
        scan_check(12);

        convert(4'd7, 4'd0, 4'd0);
        tick();
        scan_check(12);

        convert(4'hC, 4'd5, 4'd0);
        tick();
        scan_check(12);

        wait_init();
        repeat (3) tick();
        #2 rst = 1'b0;
        #1 reset_checks();
        repeat (2) tick();
        rst  = 1'b1;
        mark = cyc;
        tick();
        in_done = 1'b1;
        in_und  = 4'd8;
        in_dec  = 4'd8;
        in_cen  = 4'd8;
        tick();
        in_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("valid_after_rst", 32'(valid_b), 32'd0);
            check("an_dark",         32'(an_b),    32'(3'b111));
        end

        convert(4'd6, 4'd5, 4'd4);
        tick();
        scan_check(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
